rfid_uid_fetcher: RTL

//  Sequencer between the SPI master and the alarm state machine. On each poll tick it runs one
//  UID transaction: command 0xAA, then four 0x00 dummy bytes. It assembles the 32-bit card UID,

---
 rtl/rfid_pkg.sv | 24 ++
 rtl/rfid_poll_tick.sv | 20 ++
 rtl/rfid_uid_fetcher.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rfid_pkg.sv
// Shared types and constants for the RFID UID fetch sequencer.
package rfid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    COMPARE
  } state_t;

  localparam logic [7:0]  CMD_GET_UID = 8'hAA;
  localparam logic [7:0]  DUMMY_BYTE  = 8'h00;
  localparam logic [31:0] UID_NONE    = 32'h0000_0000;
  localparam logic [31:0] UID_FLOAT   = 32'hFFFF_FFFF;

  // An all-zero or all-one read means no tag answered on the bus.
  function automatic logic uid_is_card(input logic [31:0] u);
    return (u != UID_NONE) && (u != UID_FLOAT);
  endfunction

endpackage

// File: rtl/rfid_poll_tick.sv
// Free-running divider: one-cycle tick on the wrap cycle of a 0..DIV-1 counter.
module rfid_poll_tick #(
  parameter logic [27:0] DIV = 28'd1000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic o_tick
);

  logic [27:0] r_cnt;

  assign o_tick = (r_cnt == DIV - 28'd1);

  always_ff @(posedge CLOCK_50) begin
    if (!reset)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 28'd1;
  end

endmodule

// File: rtl/rfid_uid_fetcher.sv
// Polls the SPI reader for a 32-bit card UID and checks it against a two-entry allow-list.
// Optional macro UID_CONFIRM_EN: require two identical consecutive reads before pulsing.
module rfid_uid_fetcher
  import rfid_pkg::*;
#(
  parameter logic [27:0] POLL_DIV     = 28'd1000000,
  parameter logic [7:0]  CMD_GET_UID  = 8'hAA,
  parameter logic [31:0] UID_A        = 32'h332C1EB7,
  parameter logic [31:0] UID_B        = 32'h336BF410,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd1024
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  output logic        spi_start_n,
  output logic [7:0]  spi_tx_data,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx_data,
  output logic [31:0] uid,
  output logic        uid_valid,
  output logic        auth_ok,
  output logic        auth_fail,
  output logic        spi_err,
  output logic        active
);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [15:0] r_to_cnt;
  logic [31:0] r_shadow;
  logic        r_start_n, r_uid_valid, r_auth_ok, r_auth_fail, r_spi_err;
  logic [7:0]  r_tx;
  logic [31:0] r_uid;
  logic        w_tick, w_card, w_match, w_emit;

  rfid_poll_tick #(.DIV(POLL_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .o_tick   (w_tick)
  );

  assign w_card  = uid_is_card(r_shadow);
  assign w_match = (r_shadow == UID_A) || (r_shadow == UID_B);

`ifdef UID_CONFIRM_EN
  logic [31:0] r_cand;
  logic        r_cand_seen, r_confirmed;
  // Pulse only on the second matching read of a candidate, and only once per candidate.
  assign w_emit = w_card && r_cand_seen && (r_shadow == r_cand) && !r_confirmed;
`else
  assign w_emit = w_card;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_shadow    <= '0;
      r_start_n   <= 1'b1;
      r_tx        <= '0;
      r_uid       <= '0;
      r_uid_valid <= 1'b0;
      r_auth_ok   <= 1'b0;
      r_auth_fail <= 1'b0;
      r_spi_err   <= 1'b0;
`ifdef UID_CONFIRM_EN
      r_cand      <= '0;
      r_cand_seen <= 1'b0;
      r_confirmed <= 1'b0;
`endif
    end else begin
      r_start_n   <= 1'b1;
      r_uid_valid <= 1'b0;
      r_auth_ok   <= 1'b0;
      r_auth_fail <= 1'b0;
      r_spi_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick && enable) begin
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // Strobe is registered here so it is low exactly during START.
          r_tx      <= (r_idx == 3'd0) ? CMD_GET_UID : DUMMY_BYTE;
          r_start_n <= 1'b0;
          r_state   <= START;
        end
        START: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (spi_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_to_cnt == BUSY_TIMEOUT) begin
            r_spi_err <= 1'b1;
            r_state   <= IDLE;
`ifdef UID_CONFIRM_EN
            r_cand_seen <= 1'b0;
            r_confirmed <= 1'b0;
`endif
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!spi_busy) r_state <= CAPTURE;
        end
        CAPTURE: begin
          if (r_idx != 3'd0) r_shadow <= {r_shadow[23:0], spi_rx_data};
          if (r_idx == 3'd4) begin
            r_state <= COMPARE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= LOAD;
          end
        end
        COMPARE: begin
          if (w_emit) begin
            r_uid       <= r_shadow;
            r_uid_valid <= 1'b1;
            r_auth_ok   <= w_match;
            r_auth_fail <= !w_match;
          end
`ifdef UID_CONFIRM_EN
          if (!w_card) begin
            r_cand_seen <= 1'b0;
            r_confirmed <= 1'b0;
          end else if (!r_cand_seen || (r_shadow != r_cand)) begin
            r_cand      <= r_shadow;
            r_cand_seen <= 1'b1;
            r_confirmed <= 1'b0;
          end else begin
            r_confirmed <= 1'b1;
          end
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi_start_n = r_start_n;
  assign spi_tx_data = r_tx;
  assign uid         = r_uid;
  assign uid_valid   = r_uid_valid;
  assign auth_ok     = r_auth_ok;
  assign auth_fail   = r_auth_fail;
  assign spi_err     = r_spi_err;
  assign active      = (r_state != IDLE);

endmodule
